// File: rtl/run_gen_pkg.sv
// Shared types and defaults for the run-length pulse generator.
package run_gen_pkg;

  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } run_state_t;

endpackage

// File: rtl/run_seg_counter.sv
// Loadable down-counter timing one segment (high or low run) of a pair.
module run_seg_counter
  import run_gen_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= count - CNT_W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/run_pulse_gen.sv
// Serial run-length pulse generator: emits req_high ones then req_low zeros per accepted pair.
// Optional RUN_PULSE_GEN_STATS_EN adds a 16-bit completed-pair counter output pair_cnt.
module run_pulse_gen
  import run_gen_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_high,
  input  logic [CNT_W-1:0] req_low,
  output logic             req_ready,
  output logic             out,
  output logic             busy,
  output logic             done
`ifdef RUN_PULSE_GEN_STATS_EN
  ,
  output logic [15:0]      pair_cnt
`endif
);

  run_state_t       state;
  logic [CNT_W-1:0] low_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_val;
  logic             end_pair;
  logic             accept;

  // The final emitted cycle of a pair doubles as an accept slot for gapless streaming.
  assign end_pair  = (state == HIGH && cnt_zero && low_q == '0) || (state == LOW && cnt_zero);
  assign req_ready = !reset && (state == IDLE || end_pair);
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    if (accept) begin
      if (req_high != '0) begin
        cnt_load = 1'b1;
        cnt_val  = req_high - CNT_W'(1);
      end else if (req_low != '0) begin
        cnt_load = 1'b1;
        cnt_val  = req_low - CNT_W'(1);
      end
    end else if (state == HIGH && cnt_zero && low_q != '0) begin
      cnt_load = 1'b1;
      cnt_val  = low_q - CNT_W'(1);
    end else if (state != IDLE && !cnt_zero) begin
      cnt_en = 1'b1;
    end
  end

  run_seg_counter #(.CNT_W(CNT_W)) u_seg_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // done is registered one cycle early: it is set on the edge entering the last cycle of a pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      out   <= 1'b0;
      done  <= 1'b0;
      low_q <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        low_q <= req_low;
        if (req_high != '0) begin
          state <= HIGH;
          out   <= 1'b1;
          done  <= (req_high == CNT_W'(1)) && (req_low == '0);
        end else if (req_low != '0) begin
          state <= LOW;
          out   <= 1'b0;
          done  <= (req_low == CNT_W'(1));
        end else begin
          state <= IDLE;
          out   <= 1'b0;
          done  <= 1'b1;
        end
      end else begin
        case (state)
          HIGH: begin
            if (!cnt_zero) begin
              done <= (cnt == CNT_W'(1)) && (low_q == '0);
            end else if (low_q != '0) begin
              state <= LOW;
              out   <= 1'b0;
              done  <= (low_q == CNT_W'(1));
            end else begin
              state <= IDLE;
              out   <= 1'b0;
            end
          end
          LOW: begin
            if (!cnt_zero) done  <= (cnt == CNT_W'(1));
            else           state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef RUN_PULSE_GEN_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pair_cnt <= '0;
    else if (done) pair_cnt <= pair_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_run_pulse_gen.sv
// Self-checking bench for run_pulse_gen: table-driven pairs, scoreboard of per-cycle expectations.
module tb_run_pulse_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [7:0] req_high;
  logic [7:0] req_low;
  logic       req_ready;
  logic       out;
  logic       busy;
  logic       done;
`ifdef RUN_PULSE_GEN_STATS_EN
  logic [15:0] pair_cnt;
`endif

  run_pulse_gen #(.CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_high  (req_high),
    .req_low   (req_low),
    .req_ready (req_ready),
    .out       (out),
    .busy      (busy),
    .done      (done)
`ifdef RUN_PULSE_GEN_STATS_EN
    ,
    .pair_cnt  (pair_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic out;
    logic done;
    logic busy;
  } exp_t;

  typedef struct {
    logic [7:0] h;
    logic [7:0] l;
    int         exp_ones;
    int         exp_busy;
    int         exp_dones;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   n_vec = 0;
  int   n_err = 0;
  int   ones_cnt, busy_cnt, done_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    ones_cnt = 0;
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic push_pair(input logic [7:0] h, input logic [7:0] l);
    int hi, lo;
    hi = int'(h);
    lo = int'(l);
    if (hi == 0 && lo == 0) begin
      sb.push_back('{out: 1'b0, done: 1'b1, busy: 1'b0});
    end else begin
      for (int i = 0; i < hi; i++)
        sb.push_back('{out: 1'b1, done: (i == hi - 1 && lo == 0), busy: 1'b1});
      for (int i = 0; i < lo; i++)
        sb.push_back('{out: 1'b0, done: (i == lo - 1), busy: 1'b1});
    end
  endtask

  // One clock: note any handshake, advance, then compare the new cycle against the scoreboard.
  task automatic step(output bit acc);
    logic [7:0] h, l;
    exp_t e;
    acc = req_valid && req_ready;
    h = req_high;
    l = req_low;
    @(posedge clk);
    #1;
    if (acc) push_pair(h, l);
    if (sb.size() > 0) e = sb.pop_front();
    else               e = '{out: 1'b0, done: 1'b0, busy: 1'b0};
    check("out", 32'(out), 32'(e.out));
    check("done", 32'(done), 32'(e.done));
    check("busy", 32'(busy), 32'(e.busy));
    check("req_ready", 32'(req_ready), 32'(!e.busy || e.done));
    ones_cnt += int'(out);
    busy_cnt += int'(busy);
    done_cnt += int'(done);
  endtask

  task automatic send(input logic [7:0] h, input logic [7:0] l);
    bit acc = 1'b0;
    req_valid = 1'b1;
    req_high  = h;
    req_low   = l;
    for (int t = 0; t < 2000; t++) begin
      step(acc);
      if (acc) break;
    end
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no handshake expected one for (%0d,%0d)", h, l);
    end
  endtask

  task automatic drain();
    bit acc;
    req_valid = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (sb.size() == 0) break;
      step(acc);
    end
    step(acc);
  endtask

  initial begin
    bit acc;
    tbl[0] = '{8'd3,   8'd1,   3,   4,   1};
    tbl[1] = '{8'd0,   8'd5,   0,   5,   1};
    tbl[2] = '{8'd0,   8'd0,   0,   0,   1};
    tbl[3] = '{8'd1,   8'd0,   1,   1,   1};
    tbl[4] = '{8'd0,   8'd1,   0,   1,   1};
    tbl[5] = '{8'd1,   8'd1,   1,   2,   1};
    tbl[6] = '{8'd255, 8'd255, 255, 510, 1};
    tbl[7] = '{8'd7,   8'd2,   7,   9,   1};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_high  = '0;
    req_low   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(out), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(req_ready), 0);
    #3 reset = 1'b0;
    #1 check("ready_after_rst", 32'(req_ready), 1);

    foreach (tbl[i]) begin
      clear_counts();
      send(tbl[i].h, tbl[i].l);
      drain();
      check($sformatf("tbl%0d_ones", i), 32'(ones_cnt), 32'(tbl[i].exp_ones));
      check($sformatf("tbl%0d_busy", i), 32'(busy_cnt), 32'(tbl[i].exp_busy));
      check($sformatf("tbl%0d_dones", i), 32'(done_cnt), 32'(tbl[i].exp_dones));
    end

    // Gapless stream with req_valid held high across all three pairs.
    clear_counts();
    send(8'd6, 8'd4);
    send(8'd8, 8'd4);
    send(8'd15, 8'd5);
    drain();
    check("stream_ones", 32'(ones_cnt), 29);
    check("stream_busy", 32'(busy_cnt), 42);
    check("stream_dones", 32'(done_cnt), 3);

    // Two (4,0) pairs merge into one 8-cycle high level.
    clear_counts();
    send(8'd4, 8'd0);
    send(8'd4, 8'd0);
    drain();
    check("merge_ones", 32'(ones_cnt), 8);
    check("merge_dones", 32'(done_cnt), 2);

    // Reset during the 10th cycle of a (21,7) pair.
    clear_counts();
    send(8'd21, 8'd7);
    req_valid = 1'b0;
    repeat (9) step(acc);
    check("midrun_out_high", 32'(out), 1);
    #2 reset = 1'b1;
    #1;
    check("midrun_rst_out", 32'(out), 0);
    check("midrun_rst_busy", 32'(busy), 0);
    check("midrun_rst_ready", 32'(req_ready), 0);
    sb.delete();
    #2 reset = 1'b0;
    clear_counts();
    repeat (3) step(acc);
    check("midrun_no_done", 32'(done_cnt), 0);
    send(8'd3, 8'd1);
    drain();
    check("after_rst_ones", 32'(ones_cnt), 3);
    check("after_rst_busy", 32'(busy_cnt), 4);
    check("after_rst_dones", 32'(done_cnt), 1);

`ifdef RUN_PULSE_GEN_STATS_EN
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    #2 reset = 1'b0;
    check("stats_rst", 32'(pair_cnt), 0);
    for (int i = 0; i < 5; i++) send(8'd1, 8'd0);
    drain();
    check("stats_five", 32'(pair_cnt), 5);
    for (int i = 0; i < 65530; i++) send(8'd0, 8'd0);
    drain();
    check("stats_max", 32'(pair_cnt), 32'hFFFF);
    send(8'd0, 8'd0);
    drain();
    check("stats_wrap", 32'(pair_cnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
